// File: rtl/cpu_seq_if.sv
// Memory request bus between the instruction sequencer and its memory.
// The sequencer is the master; memory answers with mem_ready.
interface cpu_seq_if;
    logic mem_req;
    logic mem_we;
    logic ifetch;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output ifetch,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  ifetch,
        output mem_ready
    );
endinterface

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with
// run/step control, pc and instret ownership, and sticky fault halt.
module cpu_seq #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        rd_en,
    input  logic        taken_branch,
    input  logic        illegal,
    input  logic        ebreak,
    input  logic [31:0] target,
    cpu_seq_if.master   mem,
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic        ir_we,
    output logic        rf_we,
    output logic        halted,
    output logic [1:0]  fault_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic [1:0]  fault_q, fault_d;
    logic        step_mode_q, step_mode_d;
    logic [7:0]  wait_q, wait_d;

    logic mem_req_c, mem_we_c, ifetch_c;
    logic wait_exp, misalign;

    // Timeout fires on the cycle that would bring the count to MEM_TIMEOUT.
    assign wait_exp = ({1'b0, wait_q} + 9'd1) >= {1'b0, MEM_TIMEOUT};
    assign misalign = taken_branch & (target[1:0] != 2'b00);

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instret_q   <= 32'd0;
            fault_q     <= 2'd0;
            step_mode_q <= 1'b0;
            wait_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instret_q   <= instret_d;
            fault_q     <= fault_d;
            step_mode_q <= step_mode_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instret_d   = instret_q;
        fault_d     = fault_q;
        step_mode_d = step_mode_q;
        wait_d      = wait_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        ifetch_c    = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                end
                if (step) step_mode_d = 1'b1;
            end
            S_FETCH: begin
                mem_req_c = 1'b1;
                ifetch_c  = 1'b1;
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_exp) begin
                    state_d = S_HALT;
                    fault_d = 2'd2;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (illegal || ebreak) begin
                    state_d = S_HALT;
                    fault_d = 2'd1;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                    wait_d  = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = is_store;
                if (mem.mem_ready) begin
                    state_d = S_WB;
                end else if (wait_exp) begin
                    state_d = S_HALT;
                    fault_d = 2'd2;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                if (misalign) begin
                    state_d = S_HALT;
                    fault_d = 2'd3;
                end else begin
                    rf_we     = rd_en & ~is_store;
                    pc_d      = taken_branch ? target : pc_q + 32'd4;
                    instret_d = instret_q + 32'd1;
                    if (run && !step_mode_q) begin
                        state_d = S_FETCH;
                        wait_d  = 8'd0;
                    end else begin
                        state_d     = S_IDLE;
                        step_mode_d = 1'b0;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.mem_we   = mem_we_c;
    assign mem.ifetch   = ifetch_c;
    assign state        = state_q;
    assign pc           = pc_q;
    assign instret      = instret_q;
    assign fault_cause  = fault_q;
    assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_seq.sv
// Randomized self-checking bench for cpu_seq against an
// instruction-level model (pc, instret, cycle trace, strobe counts).
module tb_cpu_seq;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic        rd_en = 1'b0;
    logic        taken_branch = 1'b0;
    logic        illegal = 1'b0;
    logic        ebreak = 1'b0;
    logic [31:0] target = 32'd0;
    logic [2:0]  state;
    logic [31:0] pc;
    logic        ir_we;
    logic        rf_we;
    logic        halted;
    logic [1:0]  fault_cause;
    logic [31:0] instret;

    cpu_seq_if bus ();

    always #5 clk = ~clk;

    cpu_seq #(
        .RESET_PC   (RPC),
        .MEM_TIMEOUT(8'd4)
    ) dut (
        .CLK100MHZ   (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .is_load     (is_load),
        .is_store    (is_store),
        .rd_en       (rd_en),
        .taken_branch(taken_branch),
        .illegal     (illegal),
        .ebreak      (ebreak),
        .target      (target),
        .mem         (bus),
        .state       (state),
        .pc          (pc),
        .ir_we       (ir_we),
        .rf_we       (rf_we),
        .halted      (halted),
        .fault_cause (fault_cause),
        .instret     (instret)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    logic [63:0] o_tr;
    int          o_len, o_rf, o_we, o_ir;
    bit          o_to;
    logic [63:0] e_tr;
    int          e_len;

    // Expected state trace of one instruction, FETCH through WB.
    function automatic logic [63:0] exp_tr(input bit mem_op, input bit trap,
                                           input int fw, input int mw,
                                           output int len);
        logic [63:0] t;
        t   = 64'd0;
        len = 0;
        for (int i = 0; i <= fw && i < TMO; i++) begin
            t = {t[60:0], 3'd1};
            len++;
        end
        if (fw >= TMO) return t;
        t = {t[60:0], 3'd2};
        t = {t[60:0], 3'd3};
        len += 2;
        if (trap) return t;
        if (mem_op) begin
            for (int i = 0; i <= mw && i < TMO; i++) begin
                t = {t[60:0], 3'd4};
                len++;
            end
            if (mw >= TMO) return t;
        end
        t = {t[60:0], 3'd5};
        len++;
        return t;
    endfunction

    task automatic do_reset;
        run = 0;
        step = 0;
        is_load = 0;
        is_store = 0;
        rd_en = 0;
        taken_branch = 0;
        illegal = 0;
        ebreak = 0;
        bus.mem_ready = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        m_pc = RPC;
        m_ret = 0;
    endtask

    // Memory answers after fw (fetch) / mw (data) wait cycles.
    task automatic do_instr(input bit ld, input bit st, input bit rd,
                            input bit br, input bit trap,
                            input logic [31:0] tgt, input int fw,
                            input int mw, input int run_off);
        logic [2:0] s, prev;
        int  k;
        bit  done;
        is_load = ld;
        is_store = st;
        rd_en = rd;
        taken_branch = br;
        illegal = trap;
        target = tgt;
        o_tr = 0;
        o_len = 0;
        o_rf = 0;
        o_we = 0;
        o_ir = 0;
        o_to = 1;
        prev = 3'd7;
        k = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 1) step = 0;
            if (c == run_off) run = 0;
            s = state;
            if (s == prev) k++;
            else k = 0;
            prev = s;
            bus.mem_ready = (s == 3'd1 && k == fw) || (s == 3'd4 && k == mw);
            #1;
            if (s != 3'd0 && s != 3'd6) begin
                o_tr = {o_tr[60:0], s};
                o_len++;
            end
            o_rf += int'(rf_we);
            o_we += int'(bus.mem_we);
            o_ir += int'(ir_we);
            done = (s == 3'd5) || (s == 3'd6);
            @(negedge clk);
            if (done) begin
                o_to = 0;
                break;
            end
        end
        bus.mem_ready = 0;
    endtask

    task automatic test_reset;
        run = 1;
        rst = 1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (state !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        n_cmp++;
        if (pc !== RPC || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_pc_ret: got %h/%h want %h/0", pc, instret, RPC);
        end
        n_cmp++;
        if ({fault_cause, halted, bus.mem_req, bus.mem_we, bus.ifetch, ir_we, rf_we} !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want 0", {fault_cause, halted, bus.mem_req,
                     bus.mem_we, bus.ifetch, ir_we, rf_we});
        end
        @(negedge clk);
        n_cmp++;
        if (state !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got %0d want 0", state);
        end
        do_reset();
    endtask

    task automatic test_alu;
        do_reset();
        run = 1;
        e_tr = exp_tr(0, 0, 0, 0, e_len);
        do_instr(0, 0, 1, 0, 0, 32'd0, 0, 0, -1);
        m_pc = m_pc + 4;
        m_ret++;
        n_cmp++;
        if (o_tr !== e_tr || o_len !== e_len || o_to) begin
            n_bad++;
            $display("FAIL alu_trace: got %h/%0d want %h/%0d", o_tr, o_len, e_tr, e_len);
        end
        n_cmp++;
        if (o_rf !== 1 || o_ir !== 1) begin
            n_bad++;
            $display("FAIL alu_strobes: got rf=%0d ir=%0d want 1/1", o_rf, o_ir);
        end
        n_cmp++;
        if (pc !== m_pc || instret !== m_ret || state !== 3'd1) begin
            n_bad++;
            $display("FAIL alu_arch: got %h/%0d/%0d want %h/%0d/1", pc, instret, state, m_pc, m_ret);
        end
    endtask

    task automatic test_store;
        e_tr = exp_tr(1, 0, 0, 3, e_len);
        do_instr(0, 1, 1, 0, 0, 32'd0, 0, 3, -1);
        m_pc = m_pc + 4;
        m_ret++;
        n_cmp++;
        if (o_tr !== e_tr || o_len !== e_len || o_to) begin
            n_bad++;
            $display("FAIL store_trace: got %h/%0d want %h/%0d", o_tr, o_len, e_tr, e_len);
        end
        n_cmp++;
        if (o_we !== 4 || o_rf !== 0) begin
            n_bad++;
            $display("FAIL store_strobes: got we=%0d rf=%0d want 4/0", o_we, o_rf);
        end
        n_cmp++;
        if (pc !== m_pc || instret !== m_ret) begin
            n_bad++;
            $display("FAIL store_arch: got %h/%0d want %h/%0d", pc, instret, m_pc, m_ret);
        end
    endtask

    task automatic test_random;
        bit ld, st, rd, br;
        logic [31:0] tgt;
        int fw, mw;
        for (int n = 0; n < 30; n++) begin
            ld = ($urandom % 4) == 0;
            st = !ld && (($urandom % 3) == 0);
            rd = $urandom % 2;
            br = ($urandom % 3) == 0;
            tgt = $urandom & 32'hFFFF_FFFC;
            fw = $urandom % 4;
            mw = $urandom % 4;
            e_tr = exp_tr(ld | st, 0, fw, mw, e_len);
            do_instr(ld, st, rd, br, 0, tgt, fw, mw, -1);
            m_pc = br ? tgt : m_pc + 4;
            m_ret++;
            n_cmp++;
            if (o_tr !== e_tr || o_len !== e_len || o_to) begin
                n_bad++;
                $display("FAIL rand_trace[%0d]: got %h/%0d want %h/%0d", n, o_tr, o_len, e_tr, e_len);
            end
            n_cmp++;
            if (o_rf !== int'(rd && !st) || o_we !== (st ? mw + 1 : 0) || o_ir !== 1) begin
                n_bad++;
                $display("FAIL rand_strobes[%0d]: got rf=%0d we=%0d ir=%0d", n, o_rf, o_we, o_ir);
            end
            n_cmp++;
            if (pc !== m_pc || instret !== m_ret || state !== 3'd1) begin
                n_bad++;
                $display("FAIL rand_arch[%0d]: got %h/%0d/%0d want %h/%0d/1", n, pc, instret,
                         state, m_pc, m_ret);
            end
        end
    endtask

    task automatic test_run_drop;
        do_instr(0, 0, 1, 0, 0, 32'd0, 1, 0, 2);
        m_pc = m_pc + 4;
        m_ret++;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (state !== 3'd0 || pc !== m_pc || instret !== m_ret || o_rf !== 1) begin
            n_bad++;
            $display("FAIL run_drop: got %0d/%h/%0d/%0d want 0/%h/%0d/1", state, pc, instret,
                     o_rf, m_pc, m_ret);
        end
    endtask

    task automatic test_step;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            step = 1;
            do_instr(0, 0, 1, 0, 0, 32'd0, 0, 0, -1);
            m_pc = m_pc + 4;
            m_ret++;
            repeat (3) @(negedge clk);
            n_cmp++;
            if (state !== 3'd0 || instret !== m_ret || pc !== m_pc || o_to) begin
                n_bad++;
                $display("FAIL step[%0d]: got %0d/%0d/%h want 0/%0d/%h", p, state, instret,
                         pc, m_ret, m_pc);
            end
        end
    endtask

    task automatic test_wrap;
        do_reset();
        run = 1;
        do_instr(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0, -1);
        run = 0;
        do_instr(0, 0, 1, 0, 0, 32'd0, 0, 0, -1);
        n_cmp++;
        if (pc !== 32'd0 || instret !== 32'd2 || state !== 3'd0) begin
            n_bad++;
            $display("FAIL wrap: got %h/%0d/%0d want 0/2/0", pc, instret, state);
        end
    endtask

    task automatic test_misaligned;
        do_reset();
        run = 1;
        do_instr(0, 0, 1, 1, 0, 32'h0000_0102, 0, 0, -1);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (state !== 3'd6 || fault_cause !== 2'd3 || halted !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign_halt: got %0d/%0d/%b want 6/3/1", state, fault_cause, halted);
        end
        n_cmp++;
        if (pc !== RPC || instret !== 32'd0 || o_rf !== 0) begin
            n_bad++;
            $display("FAIL misalign_arch: got %h/%0d/%0d want %h/0/0", pc, instret, o_rf, RPC);
        end
        do_reset();
        run = 1;
        do_instr(0, 0, 1, 1, 0, 32'h0000_0100, 0, 0, -1);
        n_cmp++;
        if (pc !== 32'h100 || instret !== 32'd1 || fault_cause !== 2'd0) begin
            n_bad++;
            $display("FAIL aligned_branch: got %h/%0d/%0d want 100/1/0", pc, instret, fault_cause);
        end
    endtask

    task automatic test_trap;
        do_reset();
        run = 1;
        e_tr = exp_tr(0, 1, 2, 0, e_len);
        do_instr(0, 0, 1, 0, 1, 32'd0, 2, 0, -1);
        n_cmp++;
        if (o_tr !== e_tr || o_len !== e_len || state !== 3'd6 || fault_cause !== 2'd1) begin
            n_bad++;
            $display("FAIL trap: got %h/%0d/%0d/%0d want %h/%0d/6/1", o_tr, o_len, state,
                     fault_cause, e_tr, e_len);
        end
        n_cmp++;
        if (pc !== RPC || instret !== 32'd0 || o_rf !== 0) begin
            n_bad++;
            $display("FAIL trap_arch: got %h/%0d/%0d want %h/0/0", pc, instret, o_rf, RPC);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        run = 1;
        e_tr = exp_tr(0, 0, 99, 0, e_len);
        do_instr(0, 0, 1, 0, 0, 32'd0, 99, 0, -1);
        n_cmp++;
        if (o_tr !== e_tr || o_len !== e_len || o_ir !== 0) begin
            n_bad++;
            $display("FAIL fetch_tmo_trace: got %h/%0d ir=%0d want %h/%0d/0", o_tr, o_len,
                     o_ir, e_tr, e_len);
        end
        bus.mem_ready = 1;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (state !== 3'd6 || fault_cause !== 2'd2 || halted !== 1'b1 || pc !== RPC) begin
            n_bad++;
            $display("FAIL fetch_tmo_halt: got %0d/%0d/%b/%h want 6/2/1/%h", state,
                     fault_cause, halted, pc, RPC);
        end
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.ifetch, ir_we, rf_we} !== 5'd0) begin
            n_bad++;
            $display("FAIL halt_strobes: got %b want 0", {bus.mem_req, bus.mem_we,
                     bus.ifetch, ir_we, rf_we});
        end
        do_reset();
        run = 1;
        e_tr = exp_tr(1, 0, 0, 99, e_len);
        do_instr(1, 0, 1, 0, 0, 32'd0, 0, 99, -1);
        n_cmp++;
        if (o_tr !== e_tr || o_len !== e_len || state !== 3'd6 || fault_cause !== 2'd2 ||
            o_rf !== 0 || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL mem_tmo: got %h/%0d/%0d/%0d rf=%0d want %h/%0d/6/2/0", o_tr,
                     o_len, state, fault_cause, o_rf, e_tr, e_len);
        end
    endtask

    task automatic test_reset_mid_mem;
        bit hit;
        do_reset();
        run = 1;
        do_instr(0, 0, 1, 0, 0, 32'd0, 0, 0, -1);
        is_load = 1;
        rd_en = 1;
        bus.mem_ready = 1;
        hit = 0;
        for (int c = 0; c < 10; c++) begin
            if (state == 3'd4) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        bus.mem_ready = 0;
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL reach_mem: got state %0d want 4", state);
        end
        rst = 1;
        #1;
        n_cmp++;
        if (state !== 3'd0 || rf_we !== 1'b0 || pc !== RPC || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_mid_mem: got %0d/%b/%h/%0d want 0/0/%h/0", state, rf_we, pc,
                     instret, RPC);
        end
        run = 0;
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (state !== 3'd0 || pc !== RPC) begin
            n_bad++;
            $display("FAIL post_rst_idle: got %0d/%h want 0/%h", state, pc, RPC);
        end
    endtask

    initial begin
        bus.mem_ready = 0;
        #2;
        test_reset();
        test_alu();
        test_store();
        test_random();
        test_run_drop();
        test_step();
        test_wrap();
        test_misaligned();
        test_trap();
        test_timeout();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 8'd255, maximum wait cycles for mem_ready before fault.
REQ-003 Clocking SHALL be one clock, with reset asynchronous and active-high.
REQ-004 CLK100MHZ  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 run  input  1  level; 1 = execute continuously.
REQ-007 step  input  1  single-cycle pulse; executes exactly one instruction from IDLE.
REQ-008 is_load, is_store, rd_en, taken_branch  input  1 each  decoded/branch-unit flags, valid from EXEC onward.
REQ-009 illegal, ebreak  input  1 each  decoder trap flags, valid from EXEC onward.
REQ-010 target  input  32  branch/jump target address.
REQ-011 mem_ready  input  1  memory completion for the current request.
REQ-012 state  output  3  FSM state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-013 pc  output  32  current instruction address.
REQ-014 mem_req, mem_we, ifetch  output  1 each  memory request, write strobe, fetch qualifier.
REQ-015 ir_we, rf_we  output  1 each  instruction-register load, register-file write.
REQ-016 halted  output  1  core stopped in HALT.
REQ-017 fault_cause  output  2  0 none, 1 illegal/ebreak, 2 memory timeout, 3 misaligned target.
REQ-018 instret  output  32  retired-instruction counter.

Function
REQ-019 IDLE SHALL go to FETCH when run=1 or step=1, else hold; step seen in IDLE sets an internal step_mode flag.
REQ-020 FETCH SHALL assert mem_req=1 and ifetch=1; on mem_ready, ir_we=1 that cycle and next state is DECODE.
REQ-021 DECODE SHALL last exactly 1 cycle, then EXEC.
REQ-022 EXEC SHALL last 1 cycle and then: illegal|ebreak -> HALT with cause 1; else is_load|is_store -> MEM; else -> WB.
REQ-023 MEM SHALL assert mem_req=1 and mem_we=is_store; on mem_ready -> WB.
REQ-024 In WB, if taken_branch=1 and target[1:0]!=0, the FSM SHALL go to HALT with cause 3, with pc, instret and rf_we unchanged.
REQ-025 Otherwise in WB: rf_we=rd_en & ~is_store; pc <= taken_branch ? target : pc+4; instret += 1.
REQ-026 WB next state SHALL be FETCH if run=1 and step_mode=0, else IDLE with step_mode cleared.
REQ-027 Deasserting run mid-instruction SHALL NOT abort it: the instruction completes WB, then the FSM enters IDLE.
REQ-028 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle without mem_ready; reaching MEM_TIMEOUT -> HALT with cause 2, no ir_we/rf_we.
REQ-029 mem_ready SHALL be ignored outside FETCH/MEM; step outside IDLE SHALL be ignored.
REQ-030 HALT SHALL be sticky until rst, with halted=1 and mem_req=mem_we=ifetch=ir_we=rf_we=0.
REQ-031 mem_req, mem_we, ifetch, ir_we and rf_we SHALL be decoded from state (Moore), except ir_we, which is qualified by mem_ready.
REQ-032 pc+4 and instret SHALL wrap modulo 2^32.
REQ-033 Minimum latency SHALL be 4 cycles per ALU instruction and 5 per load/store, with 0-wait memory (mem_ready in the first request cycle).

Reset
REQ-034 While rst=1 the block SHALL hold: state=IDLE, pc=RESET_PC, instret=0, fault_cause=0, step_mode=0, wait counter=0, all strobes and halted 0.
REQ-035 rst asserted in any state (including mid-MEM) SHALL abort immediately with no rf_we and no pc update; run is sampled again after release.

Verification
REQ-036 run=1, mem_ready=1 always, ALU instruction at pc=0 -> state 1,2,3,5,1; rf_we pulses once; pc=4; instret=1 after 4 cycles.
REQ-037 Store with mem_ready delayed 3 cycles in MEM -> mem_we=1 for 4 cycles; rf_we=0; pc+=4.
REQ-038 run=0, single step pulse -> exactly one instruction retires, then state=0, instret=1; a second pulse retires the next.
REQ-039 mem_ready held 0 in FETCH, MEM_TIMEOUT=4 -> HALT after 4 cycles; fault_cause=2; pc unchanged; stays halted until rst.
REQ-040 taken_branch=1 with target=32'h0000_0102 -> HALT, fault_cause=3, pc unchanged; with target=32'h0000_0100 -> pc=0x100.
REQ-041 pc=32'hFFFF_FFFC, non-branch -> pc=0 after WB; rst pulse asserted mid-MEM -> pc=RESET_PC, no rf_we.
